// File: rtl/ladybird_fetch_pkg.sv
// Shared types for the ladybird instruction fetch unit: queue entry layout,
// fetch FSM states and the fetch address step.
package ladybird_config;

    localparam logic [31:0] PC_STEP = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } fetch_state_t;

    // Fetch addresses are always word aligned; low bits of a target are ignored.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ladybird_bus.sv
// Instruction memory bus: the fetch unit is the primary, memory the secondary.
// data is a shared wire so a read-only primary can leave it undriven ('z).
interface ladybird_bus;

    logic        req;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    wire  [31:0] data;
    logic        gnt;
    logic        data_gnt;

    modport primary (
        output req,
        output addr,
        output wstrb,
        inout  data,
        input  gnt,
        input  data_gnt
    );

    modport secondary (
        input  req,
        input  addr,
        input  wstrb,
        inout  data,
        output gnt,
        output data_gnt
    );

endinterface

// File: rtl/ladybird_fetch_queue.sv
// Synchronous FIFO of fetched {pc, inst} entries with a single-cycle flush.
// A push into a full queue is accepted only when a pop happens in the same cycle.
module ladybird_fetch_queue
    import ladybird_config::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     anrst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  fetch_entry_t             push_data,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    fetch_entry_t    mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_C);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge anrst) begin
        if (!anrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
        end
    end

    // Storage needs no reset: an entry is only visible once count covers it.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/ladybird_fetch.sv
// Read-only instruction fetch unit with credit-limited prefetch queue and redirect.
// Build option LADYBIRD_FETCH_BYPASS_EN forwards a response straight to inst when the queue is empty.
module ladybird_fetch
    import ladybird_config::*;
#(
    parameter int          QUEUE_DEPTH = 4,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        anrst,
    ladybird_bus.primary bus,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
);

    localparam int CW = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(QUEUE_DEPTH);

    fetch_state_t  state;
    logic [31:0]   pc;
    logic [31:0]   resp_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;
    logic [CW-1:0] remaining;
    logic [CW-1:0] q_count;

    logic          credit_ok;
    logic          issue;
    logic          resp;
    logic          keep;
    logic          bypass_valid;
    logic          q_push;
    logic          q_pop;
    logic          q_full;
    logic          q_empty;
    fetch_entry_t  q_head;
    fetch_entry_t  resp_entry;

    assign bus.wstrb = 4'b0000;
    assign bus.data  = 32'bz;

    // Every issued request must already own a queue slot for its response.
    assign credit_ok = ({1'b0, outstanding} + {1'b0, q_count}) < DEPTH_C;
    assign bus.req   = anrst && (state == RUN) && !redirect_valid && credit_ok;
    assign bus.addr  = anrst ? pc : 32'h0000_0000;
    assign issue     = bus.req && bus.gnt;

    assign resp       = bus.data_gnt && (outstanding != '0);
    assign remaining  = outstanding - CW'(resp);
    assign keep       = resp && (state == RUN) && !redirect_valid;
    assign resp_entry = '{pc: resp_pc, inst: bus.data};

`ifdef LADYBIRD_FETCH_BYPASS_EN
    assign bypass_valid = keep && q_empty;
`else
    assign bypass_valid = 1'b0;
`endif

    assign q_push     = keep && !(bypass_valid && inst_ready) && (!q_full || q_pop);
    assign q_pop      = !q_empty && inst_ready && !redirect_valid;
    assign inst_valid = !q_empty || bypass_valid;

    always_comb begin
        inst    = 32'h0000_0000;
        inst_pc = 32'h0000_0000;
        if (!q_empty) begin
            inst    = q_head.inst;
            inst_pc = q_head.pc;
        end else if (bypass_valid) begin
            inst    = resp_entry.inst;
            inst_pc = resp_entry.pc;
        end
    end

    ladybird_fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk       (clk),
        .anrst     (anrst),
        .push      (q_push),
        .pop       (q_pop),
        .flush     (redirect_valid),
        .push_data (resp_entry),
        .head      (q_head),
        .count     (q_count),
        .full      (q_full),
        .empty     (q_empty)
    );

    // Responses still in flight at a redirect belong to the old stream; DRAIN
    // swallows exactly that many before fetching from the new pc.
    always_ff @(posedge clk or negedge anrst) begin
        if (!anrst) begin
            state       <= RUN;
            pc          <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else if (redirect_valid) begin
            pc          <= align_pc(redirect_pc);
            resp_pc     <= align_pc(redirect_pc);
            outstanding <= remaining;
            discard     <= remaining;
            state       <= (remaining != '0) ? DRAIN : RUN;
        end else begin
            if (issue) begin
                pc <= pc + PC_STEP;
            end
            outstanding <= outstanding + CW'(issue) - CW'(resp);
            case (state)
                RUN: begin
                    if (resp) begin
                        resp_pc <= resp_pc + PC_STEP;
                    end
                end
                DRAIN: begin
                    if (resp) begin
                        discard <= discard - CW'(1);
                    end
                    if ((discard == '0) || (resp && (discard == CW'(1)))) begin
                        state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_ladybird_fetch.sv
// Directed bench for ladybird_fetch: two DUTs (RESET_PC 0 and FFFF_FFF8) with
// in-order memory responders; expected latency follows LADYBIRD_FETCH_BYPASS_EN.
module tb_ladybird_fetch;
    import ladybird_config::*;

`ifdef LADYBIRD_FETCH_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        anrst0, anrst1;
    logic        gnt0, gnt1, hold0;
    logic        redir_valid0;
    logic [31:0] redir_pc0;
    logic        inst_ready0, inst_ready1;
    logic        inst_valid0, inst_valid1;
    logic [31:0] inst0, inst1, inst_pc0, inst_pc1;
    logic        dg0, dg1;
    logic [31:0] rd0, rd1;
    logic [31:0] pend0 [$];
    logic [31:0] pend1 [$];

    int checks = 0;
    int errors = 0;

    ladybird_bus bus0 ();
    ladybird_bus bus1 ();

    assign bus0.gnt      = gnt0;
    assign bus0.data_gnt = dg0;
    assign bus0.data     = rd0;
    assign bus1.gnt      = gnt1;
    assign bus1.data_gnt = dg1;
    assign bus1.data     = rd1;

    ladybird_fetch #(.QUEUE_DEPTH(4), .RESET_PC(32'h0000_0000)) dut0 (
        .clk(clk), .anrst(anrst0), .bus(bus0),
        .redirect_valid(redir_valid0), .redirect_pc(redir_pc0),
        .inst_valid(inst_valid0), .inst_ready(inst_ready0),
        .inst(inst0), .inst_pc(inst_pc0)
    );

    ladybird_fetch #(.QUEUE_DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut1 (
        .clk(clk), .anrst(anrst1), .bus(bus1),
        .redirect_valid(1'b0), .redirect_pc(32'h0000_0000),
        .inst_valid(inst_valid1), .inst_ready(inst_ready1),
        .inst(inst1), .inst_pc(inst_pc1)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_1234;
    endfunction

    // In-order memory: accepted requests queue up and answer one per cycle,
    // the cycle after acceptance unless hold0 stalls dut0's responses.
    always @(posedge clk or negedge anrst0) begin
        if (!anrst0) begin
            pend0.delete();
            dg0 <= 1'b0;
            rd0 <= 32'h0;
        end else begin
            if (bus0.req && bus0.gnt) pend0.push_back(bus0.addr);
            if (!hold0 && pend0.size() > 0) begin
                dg0 <= 1'b1;
                rd0 <= mem_word(pend0.pop_front());
            end else begin
                dg0 <= 1'b0;
            end
        end
    end

    always @(posedge clk or negedge anrst1) begin
        if (!anrst1) begin
            pend1.delete();
            dg1 <= 1'b0;
            rd1 <= 32'h0;
        end else begin
            if (bus1.req && bus1.gnt) pend1.push_back(bus1.addr);
            if (pend1.size() > 0) begin
                dg1 <= 1'b1;
                rd1 <= mem_word(pend1.pop_front());
            end else begin
                dg1 <= 1'b0;
            end
        end
    end

    task automatic do_reset0();
        @(negedge clk);
        anrst0       = 1'b0;
        redir_valid0 = 1'b0;
        @(negedge clk);
        anrst0 = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (bus0.req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req got %b want 0", bus0.req); end
        checks++; if (bus0.addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_addr got %h want 0", bus0.addr); end
        checks++; if (bus0.wstrb !== 4'h0) begin errors++; $display("[TB] FAIL reset_wstrb got %h want 0", bus0.wstrb); end
        checks++; if (inst_valid0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b want 0", inst_valid0); end
        checks++; if (inst0 !== 32'h0 || inst_pc0 !== 32'h0) begin errors++; $display("[TB] FAIL reset_inst got %h/%h want 0/0", inst0, inst_pc0); end
        checks++; if (bus1.addr !== 32'h0 || bus1.req !== 1'b0) begin errors++; $display("[TB] FAIL reset_addr_hi got %h/%b want 0/0", bus1.addr, bus1.req); end
    endtask

    task automatic test_startup();
        @(negedge clk);
        anrst0 = 1'b1;
        #1;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) begin @(negedge clk); #1; end
            checks++;
            if (bus0.req !== 1'b1 || bus0.addr !== 32'(4 * k)) begin
                errors++; $display("[TB] FAIL start_addr k=%0d got %b/%h want 1/%h", k, bus0.req, bus0.addr, 32'(4 * k));
            end
            checks++;
            if (inst_valid0 !== (k >= LAT)) begin
                errors++; $display("[TB] FAIL start_valid k=%0d got %b want %b", k, inst_valid0, (k >= LAT));
            end else if (k >= LAT) begin
                checks++;
                if (inst_pc0 !== 32'(4 * (k - LAT)) || inst0 !== mem_word(32'(4 * (k - LAT)))) begin
                    errors++; $display("[TB] FAIL start_inst k=%0d got %h/%h want %h", k, inst_pc0, inst0, 32'(4 * (k - LAT)));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int issued = 0;
        inst_ready0 = 1'b0;
        do_reset0();
        for (int k = 0; k < 10; k++) begin
            if (k > 0) begin @(negedge clk); #1; end
            if (bus0.req && gnt0) issued++;
        end
        checks++; if (issued != 4) begin errors++; $display("[TB] FAIL bp_issued got %0d want 4", issued); end
        checks++; if (bus0.req !== 1'b0) begin errors++; $display("[TB] FAIL bp_req_full got %b want 0", bus0.req); end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            inst_ready0 = 1'b1;
            #1;
            checks++;
            if (inst_valid0 !== 1'b1 || inst_pc0 !== 32'(4 * i) || inst0 !== mem_word(32'(4 * i))) begin
                errors++; $display("[TB] FAIL bp_drain i=%0d got %b/%h/%h want 1/%h", i, inst_valid0, inst_pc0, inst0, 32'(4 * i));
            end
        end
    endtask

    task automatic test_redirect_drain();
        hold0 = 1'b1;
        do_reset0();
        @(negedge clk);
        @(negedge clk);
        redir_valid0 = 1'b1;
        redir_pc0    = 32'h0000_0100;
        hold0        = 1'b0;
        #1;
        checks++; if (bus0.req !== 1'b0) begin errors++; $display("[TB] FAIL redir_cycle_req got %b want 0", bus0.req); end
        for (int k = 3; k <= 5 + LAT; k++) begin
            @(negedge clk);
            redir_valid0 = 1'b0;
            #1;
            checks++;
            if (bus0.req !== (k >= 5)) begin
                errors++; $display("[TB] FAIL drain_req k=%0d got %b want %b", k, bus0.req, (k >= 5));
            end
            if (k == 5) begin
                checks++;
                if (bus0.addr !== 32'h100) begin errors++; $display("[TB] FAIL drain_addr got %h want 00000100", bus0.addr); end
            end
            checks++;
            if (inst_valid0 !== (k == 5 + LAT)) begin
                errors++; $display("[TB] FAIL drain_valid k=%0d got %b want %b", k, inst_valid0, (k == 5 + LAT));
            end else if (k == 5 + LAT) begin
                checks++;
                if (inst_pc0 !== 32'h100 || inst0 !== mem_word(32'h100)) begin
                    errors++; $display("[TB] FAIL drain_first got %h/%h want 00000100/%h", inst_pc0, inst0, mem_word(32'h100));
                end
            end
        end
    endtask

    task automatic test_align();
        repeat (3) @(negedge clk);
        @(negedge clk);
        redir_valid0 = 1'b1;
        redir_pc0    = 32'h0000_0203;
        #1;
        checks++; if (bus0.req !== 1'b0) begin errors++; $display("[TB] FAIL align_redir_req got %b want 0", bus0.req); end
        @(negedge clk);
        redir_valid0 = 1'b0;
        #1;
        checks++;
        if (bus0.req !== 1'b1 || bus0.addr !== 32'h200) begin
            errors++; $display("[TB] FAIL align_addr got %b/%h want 1/00000200", bus0.req, bus0.addr);
        end
        checks++; if (inst_valid0 !== 1'b0) begin errors++; $display("[TB] FAIL align_flush got %b want 0", inst_valid0); end
        for (int j = 1; j <= LAT; j++) begin
            @(negedge clk); #1;
            checks++;
            if (inst_valid0 !== (j == LAT)) begin
                errors++; $display("[TB] FAIL align_valid j=%0d got %b want %b", j, inst_valid0, (j == LAT));
            end else if (j == LAT && inst_pc0 !== 32'h200) begin
                errors++; $display("[TB] FAIL align_inst_pc got %h want 00000200", inst_pc0);
            end
        end
    endtask

    task automatic test_gnt_stall();
        logic [31:0] a_hold   = 32'h200 + 32'(4 * (LAT + 1));
        logic [31:0] exp_next = a_hold - 32'(4 * LAT);
        int          hits     = 0;
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            if (t == 0) gnt0 = 1'b0;
            if (t == 3) gnt0 = 1'b1;
            #1;
            if (t <= 3) begin
                checks++;
                if (bus0.req !== 1'b1 || bus0.addr !== a_hold || dut0.pc !== a_hold) begin
                    errors++; $display("[TB] FAIL stall_hold t=%0d got %b/%h want 1/%h", t, bus0.req, bus0.addr, a_hold);
                end
            end
            if (t == 4) begin
                checks++;
                if (bus0.addr !== a_hold + 32'd4) begin errors++; $display("[TB] FAIL stall_next got %h want %h", bus0.addr, a_hold + 32'd4); end
            end
            if (inst_valid0 && inst_ready0) begin
                checks++;
                if (inst_pc0 !== exp_next) begin
                    errors++; $display("[TB] FAIL stall_stream t=%0d got %h want %h", t, inst_pc0, exp_next);
                end
                if (inst_pc0 === a_hold) hits++;
                exp_next = exp_next + 32'd4;
            end
        end
        checks++; if (hits != 1) begin errors++; $display("[TB] FAIL stall_once got %0d want 1", hits); end
    endtask

    task automatic test_wrap();
        logic [31:0] e;
        @(negedge clk);
        anrst1 = 1'b1;
        #1;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) begin @(negedge clk); #1; end
            e = 32'hFFFF_FFF8 + 32'(4 * k);
            checks++;
            if (bus1.req !== 1'b1 || bus1.addr !== e) begin
                errors++; $display("[TB] FAIL wrap_addr k=%0d got %b/%h want 1/%h", k, bus1.req, bus1.addr, e);
            end
            if (k >= LAT) begin
                e = 32'hFFFF_FFF8 + 32'(4 * (k - LAT));
                checks++;
                if (inst_valid1 !== 1'b1 || inst_pc1 !== e || inst1 !== mem_word(e)) begin
                    errors++; $display("[TB] FAIL wrap_inst k=%0d got %b/%h/%h want 1/%h", k, inst_valid1, inst_pc1, inst1, e);
                end
            end
        end
    endtask

    task automatic test_reset_mid_drain();
        hold0 = 1'b1;
        do_reset0();
        @(negedge clk);
        @(negedge clk);
        redir_valid0 = 1'b1;
        redir_pc0    = 32'h0000_0300;
        #1;
        @(negedge clk);
        redir_valid0 = 1'b0;
        #1;
        checks++; if (dut0.state !== DRAIN) begin errors++; $display("[TB] FAIL mid_in_drain got %b want 1", dut0.state); end
        #2;
        anrst0 = 1'b0;
        #1;
        checks++; if (bus0.req !== 1'b0 || bus0.addr !== 32'h0) begin errors++; $display("[TB] FAIL mid_bus got %b/%h want 0/0", bus0.req, bus0.addr); end
        checks++; if (inst_valid0 !== 1'b0 || inst0 !== 32'h0 || inst_pc0 !== 32'h0) begin errors++; $display("[TB] FAIL mid_inst got %b/%h/%h want 0/0/0", inst_valid0, inst0, inst_pc0); end
        checks++; if (dut0.state !== RUN || dut0.outstanding !== '0 || dut0.discard !== '0) begin errors++; $display("[TB] FAIL mid_fsm got %b/%0d/%0d want 0/0/0", dut0.state, dut0.outstanding, dut0.discard); end
        checks++; if (dut0.pc !== 32'h0) begin errors++; $display("[TB] FAIL mid_pc got %h want 0", dut0.pc); end
        @(negedge clk);
        hold0  = 1'b0;
        anrst0 = 1'b1;
        #1;
        checks++; if (bus0.req !== 1'b1 || bus0.addr !== 32'h0) begin errors++; $display("[TB] FAIL mid_restart got %b/%h want 1/0", bus0.req, bus0.addr); end
        for (int j = 1; j <= LAT; j++) begin
            @(negedge clk); #1;
            checks++;
            if (inst_valid0 !== (j == LAT) || (j == LAT && inst_pc0 !== 32'h0)) begin
                errors++; $display("[TB] FAIL mid_first j=%0d got %b/%h want %b/0", j, inst_valid0, inst_pc0, (j == LAT));
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        anrst0       = 1'b0;
        anrst1       = 1'b0;
        gnt0         = 1'b1;
        gnt1         = 1'b1;
        hold0        = 1'b0;
        redir_valid0 = 1'b0;
        redir_pc0    = 32'h0;
        inst_ready0  = 1'b1;
        inst_ready1  = 1'b1;
        $display("[TB] ladybird_fetch bench, response latency %0d", LAT);
        test_reset();
        test_startup();
        test_backpressure();
        test_redirect_drain();
        test_align();
        test_gnt_stall();
        test_wrap();
        test_reset_mid_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
